amf_window_controller: RTL and testbench
========================================

// Module: amf_window_controller
// PURPOSE
//  Per-pixel sequencer for the adaptive median filter. Escalates the window (WIN_MIN, +2, ... WIN_MAX)
//  and requests min/med/max for each size from the window-statistics datapath. Runs stage A
//  (zmin<zmed<zmax) and stage B (zmin<zxy<zmax), and drives noiseF to the output-selection mux.
//  Sits between the pixel/window buffer and the output stage, with valid/ready on both ends.
// PARAMETERS
//  DATA_WIDTH  8  pixel width (unsigned)
//  WIN_MIN     3  first window size; odd, >=3
//  WIN_MAX     7  largest window size; odd, >=WIN_MIN
//  WIN_W       4  width of win_size; must hold WIN_MAX
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  in_valid   in   1           centre pixel zxy offered
//  in_ready   out  1           controller idle, accepts a pixel
//  zxy        in   DATA_WIDTH  centre pixel, captured on accept
//  win_size   out  WIN_W       window size for the statistics datapath
//  stat_req   out  1           1-cycle pulse: compute stats for win_size
//  stat_valid in   1           zmin/zmed/zmax valid (sampled only in WAIT)
//  zmin       in   DATA_WIDTH  window minimum
//  zmed       in   DATA_WIDTH  window median
//  zmax       in   DATA_WIDTH  window maximum
//  out_pixel  out  DATA_WIDTH  filtered pixel
//  noiseF     out  1           1 = zmed chosen, 0 = zxy kept
//  out_valid  out  1           result valid, held until out_ready
//  out_ready  in   1           downstream accepts result
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, OUT. All outputs are registered except in_ready = (state==IDLE).
//  - Reset (async, rst=1):
//    - state=IDLE, win_size=WIN_MIN; stat_req, out_valid, noiseF and out_pixel all 0.
//    - zxy register cleared to 0; in_valid is ignored while rst=1.
//  - IDLE: when in_valid & in_ready, capture zxy and go to REQ.
//  - REQ: stat_req=1 for exactly one cycle, then go to WAIT. win_size stays stable from REQ until the next change.
//  - WAIT: hold until stat_valid=1. stat_valid is ignored in every other state. Decide in the stat_valid cycle.
//    All compares are unsigned and strict (equality fails).
//    - Stage A passes, stage B passes: out_pixel=zxy, noiseF=0, go to OUT.
//    - Stage A passes, stage B fails: out_pixel=zmed, noiseF=1, go to OUT.
//    - Stage A fails, win_size+2 <= WIN_MAX: win_size += 2, go to REQ. Compute the sum WIN_W+1 wide; no wrap.
//    - Stage A fails, win_size == WIN_MAX: out_pixel=zmed, noiseF=1, go to OUT.
//  - OUT: out_valid=1; out_pixel and noiseF held stable. On out_ready: out_valid=0, win_size=WIN_MIN, go to IDLE.
//    in_ready rises the cycle after the handshake (no same-cycle re-accept).
//  - Latency with zero-wait stats: accept at T, stat_req at T+1, stat_valid at T+2, out_valid at T+3.
//    Each escalation adds 2 cycles plus the datapath wait.
//  - At most (WIN_MAX-WIN_MIN)/2+1 stat_req pulses per pixel.
//  - rst mid-operation aborts the pixel immediately; no out_valid is produced for it.
//    A stat_valid arriving after reset is ignored.
//  - out_ready while not in OUT has no effect. noiseF/out_pixel keep their last values in IDLE.
// TESTING
//  1. rst=1 mid-stream -> out_valid=0, stat_req=0, noiseF=0, out_pixel=0, win_size=3, in_ready=1 after release.
//  2. zxy=100, stats(3)=(50,100,200) -> one stat_req at win 3; out_pixel=100, noiseF=0, out_valid at T+3.
//  3. zxy=255, stats(3)=(10,80,255) -> stage B fails (zxy==zmax); out_pixel=80, noiseF=1.
//  4. zxy=0, stats(3)=(0,0,255), stats(5)=(20,90,200) -> stat_req at 3 then 5; out_pixel=90, noiseF=1; 2 requests.
//  5. every window returns (0,0,0) -> requests at 3,5,7 only; out_pixel=0, noiseF=1; no 4th request.
//  6. out_ready=0 for 5 cycles -> out_valid/out_pixel stable; rst in WAIT -> IDLE, win_size=3, late stat_valid ignored.

Source files
------------

// File: rtl/amf_window_controller.sv
// Per-pixel window sequencer for the adaptive median filter: escalates the window size,
// requests min/med/max statistics and resolves stage A / stage B into the output pixel.
module amf_window_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_MIN    = 3,
  parameter int WIN_MAX    = 7,
  parameter int WIN_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] zxy,
  output logic [WIN_W-1:0]      win_size,
  output logic                  stat_req,
  input  logic                  stat_valid,
  input  logic [DATA_WIDTH-1:0] zmin,
  input  logic [DATA_WIDTH-1:0] zmed,
  input  logic [DATA_WIDTH-1:0] zmax,
  output logic [DATA_WIDTH-1:0] out_pixel,
  output logic                  noiseF,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [WIN_W-1:0] WIN_MIN_V = WIN_W'(WIN_MIN);
  localparam logic [WIN_W:0]   WIN_MAX_V = (WIN_W + 1)'(WIN_MAX);

  state_t                state_q, state_d;
  logic [WIN_W-1:0]      win_size_q, win_size_d;
  logic [DATA_WIDTH-1:0] zxy_q, zxy_d;
  logic [DATA_WIDTH-1:0] out_pixel_q, out_pixel_d;
  logic                  noise_q, noise_d;
  logic                  stat_req_q, stat_req_d;
  logic                  out_valid_q, out_valid_d;

  // One extra bit so the escalated size can never wrap past WIN_MAX.
  logic [WIN_W:0] win_inc;
  logic           stage_a;
  logic           stage_b;

  assign win_inc = {1'b0, win_size_q} + (WIN_W + 1)'(2);
  assign stage_a = (zmin < zmed) && (zmed < zmax);
  assign stage_b = (zmin < zxy_q) && (zxy_q < zmax);

  always_comb begin
    state_d     = state_q;
    win_size_d  = win_size_q;
    zxy_d       = zxy_q;
    out_pixel_d = out_pixel_q;
    noise_d     = noise_q;
    stat_req_d  = 1'b0;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          zxy_d      = zxy;
          stat_req_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stat_valid) begin
          if (stage_a) begin
            out_pixel_d = stage_b ? zxy_q : zmed;
            noise_d     = ~stage_b;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else if (win_inc <= WIN_MAX_V) begin
            win_size_d = win_inc[WIN_W-1:0];
            stat_req_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            out_pixel_d = zmed;
            noise_d     = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          win_size_d = WIN_MIN_V;
          state_d    = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_size_q  <= WIN_MIN_V;
      zxy_q       <= '0;
      out_pixel_q <= '0;
      noise_q     <= 1'b0;
      stat_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_size_q  <= win_size_d;
      zxy_q       <= zxy_d;
      out_pixel_q <= out_pixel_d;
      noise_q     <= noise_d;
      stat_req_q  <= stat_req_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign win_size  = win_size_q;
  assign stat_req  = stat_req_q;
  assign out_pixel = out_pixel_q;
  assign noiseF    = noise_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_amf_window_controller.sv
// Bench for amf_window_controller: a table-driven statistics responder plus a scoreboard
// of expected filtered pixels, exercised one scenario task at a time.
module tb_amf_window_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] zxy;
  logic [3:0] win_size;
  logic       stat_req;
  logic       stat_valid;
  logic [7:0] zmin, zmed, zmax;
  logic [7:0] out_pixel;
  logic       noiseF;
  logic       out_valid;
  logic       out_ready;

  typedef struct packed {
    logic [7:0] pix;
    logic       noise;
  } exp_t;

  int         total = 0;
  int         bad = 0;
  int         req_cycles = 0;
  int         stat_delay = 0;
  logic [7:0] tab_min [16];
  logic [7:0] tab_med [16];
  logic [7:0] tab_max [16];
  logic [3:0] req_log [$];
  exp_t       sb_q [$];

  amf_window_controller #(
    .DATA_WIDTH(8),
    .WIN_MIN   (3),
    .WIN_MAX   (7),
    .WIN_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .zxy       (zxy),
    .win_size  (win_size),
    .stat_req  (stat_req),
    .stat_valid(stat_valid),
    .zmin      (zmin),
    .zmed      (zmed),
    .zmax      (zmax),
    .out_pixel (out_pixel),
    .noiseF    (noiseF),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stat_req === 1'b1) req_cycles <= req_cycles + 1;
  end

  // Statistics datapath model: answers each request stat_delay cycles into WAIT.
  initial begin
    logic [3:0] w;
    stat_valid = 1'b0;
    zmin = '0;
    zmed = '0;
    zmax = '0;
    @(posedge clk);
    #1;
    forever begin
      if (stat_req === 1'b1) begin
        w = win_size;
        req_log.push_back(w);
        @(posedge clk);
        #1;
        repeat (stat_delay) begin
          @(posedge clk);
          #1;
        end
        zmin = tab_min[w];
        zmed = tab_med[w];
        zmax = tab_max[w];
        stat_valid = 1'b1;
        @(posedge clk);
        #1;
        stat_valid = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic set_stats(input int w, input logic [7:0] mn, input logic [7:0] md, input logic [7:0] mx);
    tab_min[w] = mn;
    tab_med[w] = md;
    tab_max[w] = mx;
  endtask

  task automatic send_pixel(input logic [7:0] pix, input logic [7:0] exp_pix, input logic exp_noise);
    exp_t e;
    e.pix   = exp_pix;
    e.noise = exp_noise;
    sb_q.push_back(e);
    zxy      = pix;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (out_valid !== 1'b1) cyc = -1;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    zxy      = 8'd55;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    total++; if (stat_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_stat_req: got %0b expected 0", stat_req); end
    total++; if (noiseF !== 1'b0) begin bad++; $display("[TB] FAIL reset_noiseF: got %0b expected 0", noiseF); end
    total++; if (out_pixel !== 8'd0) begin bad++; $display("[TB] FAIL reset_out_pixel: got %0d expected 0", out_pixel); end
    total++; if (win_size !== 4'd3) begin bad++; $display("[TB] FAIL reset_win_size: got %0d expected 3", win_size); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_cycles !== 0) begin bad++; $display("[TB] FAIL reset_ignores_in_valid: got %0d requests expected 0", req_cycles); end
  endtask

  task automatic test_pass_through();
    int   cyc;
    int   r0;
    exp_t e;
    set_stats(3, 8'd50, 8'd100, 8'd200);
    stat_delay = 0;
    req_log.delete();
    r0 = req_cycles;
    send_pixel(8'd100, 8'd100, 1'b0);
    wait_out(cyc);
    e = sb_q.pop_front();
    total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL pass_latency: got %0d cycles after accept expected 2", cyc); end
    total++; if (out_pixel !== e.pix) begin bad++; $display("[TB] FAIL pass_pixel: got %0d expected %0d", out_pixel, e.pix); end
    total++; if (noiseF !== e.noise) begin bad++; $display("[TB] FAIL pass_noiseF: got %0b expected %0b", noiseF, e.noise); end
    total++; if (req_cycles - r0 !== 1) begin bad++; $display("[TB] FAIL pass_req_count: got %0d expected 1", req_cycles - r0); end
    total++; if (req_log.size() !== 1 || req_log[0] !== 4'd3) begin bad++; $display("[TB] FAIL pass_req_window: got %0d entries expected one at 3", req_log.size()); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL pass_busy_in_ready: got %0b expected 0", in_ready); end
    finish_out();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL pass_out_drop: got %0b expected 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL pass_in_ready_back: got %0b expected 1", in_ready); end
  endtask

  task automatic test_stage_b_fail();
    int   cyc;
    exp_t e;
    set_stats(3, 8'd10, 8'd80, 8'd255);
    stat_delay = 1;
    send_pixel(8'd255, 8'd80, 1'b1);
    wait_out(cyc);
    e = sb_q.pop_front();
    total++; if (cyc < 0) begin bad++; $display("[TB] FAIL stageb_timeout: got no out_valid expected out_valid"); end
    total++; if (out_pixel !== e.pix) begin bad++; $display("[TB] FAIL stageb_pixel: got %0d expected %0d", out_pixel, e.pix); end
    total++; if (noiseF !== e.noise) begin bad++; $display("[TB] FAIL stageb_noiseF: got %0b expected %0b", noiseF, e.noise); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_pixel !== e.pix || noiseF !== e.noise) begin
        bad++;
        $display("[TB] FAIL stall_hold: got valid=%0b pixel=%0d noise=%0b expected valid=1 pixel=%0d noise=%0b",
                 out_valid, out_pixel, noiseF, e.pix, e.noise);
      end
    end
    finish_out();
  endtask

  task automatic test_escalate_once();
    int         cyc;
    int         r0;
    exp_t       e;
    logic [3:0] exp_win [$];
    set_stats(3, 8'd0, 8'd0, 8'd255);
    set_stats(5, 8'd20, 8'd90, 8'd200);
    stat_delay = 2;
    req_log.delete();
    exp_win = '{4'd3, 4'd5};
    r0 = req_cycles;
    send_pixel(8'd0, 8'd90, 1'b1);
    wait_out(cyc);
    e = sb_q.pop_front();
    total++; if (cyc < 0) begin bad++; $display("[TB] FAIL esc_timeout: got no out_valid expected out_valid"); end
    total++; if (out_pixel !== e.pix) begin bad++; $display("[TB] FAIL esc_pixel: got %0d expected %0d", out_pixel, e.pix); end
    total++; if (noiseF !== e.noise) begin bad++; $display("[TB] FAIL esc_noiseF: got %0b expected %0b", noiseF, e.noise); end
    total++; if (req_cycles - r0 !== 2) begin bad++; $display("[TB] FAIL esc_req_count: got %0d expected 2", req_cycles - r0); end
    total++; if (req_log.size() !== exp_win.size()) begin bad++; $display("[TB] FAIL esc_req_log_len: got %0d expected %0d", req_log.size(), exp_win.size()); end
    for (int i = 0; i < exp_win.size() && i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_win[i]) begin bad++; $display("[TB] FAIL esc_req_window: got %0d expected %0d", req_log[i], exp_win[i]); end
    end
    total++; if (win_size !== 4'd5) begin bad++; $display("[TB] FAIL esc_win_hold: got %0d expected 5", win_size); end
    finish_out();
    total++; if (win_size !== 4'd3) begin bad++; $display("[TB] FAIL esc_win_restore: got %0d expected 3", win_size); end
  endtask

  task automatic test_max_window();
    int         cyc;
    int         r0;
    exp_t       e;
    logic [3:0] exp_win [$];
    set_stats(3, 8'd0, 8'd0, 8'd0);
    set_stats(5, 8'd0, 8'd0, 8'd0);
    set_stats(7, 8'd0, 8'd0, 8'd0);
    set_stats(9, 8'd0, 8'd0, 8'd0);
    stat_delay = 0;
    req_log.delete();
    exp_win = '{4'd3, 4'd5, 4'd7};
    r0 = req_cycles;
    send_pixel(8'd77, 8'd0, 1'b1);
    wait_out(cyc);
    e = sb_q.pop_front();
    total++; if (cyc < 0) begin bad++; $display("[TB] FAIL max_timeout: got no out_valid expected out_valid"); end
    total++; if (out_pixel !== e.pix) begin bad++; $display("[TB] FAIL max_pixel: got %0d expected %0d", out_pixel, e.pix); end
    total++; if (noiseF !== e.noise) begin bad++; $display("[TB] FAIL max_noiseF: got %0b expected %0b", noiseF, e.noise); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_cycles - r0 !== 3) begin bad++; $display("[TB] FAIL max_req_count: got %0d expected 3", req_cycles - r0); end
    total++; if (req_log.size() !== exp_win.size()) begin bad++; $display("[TB] FAIL max_req_log_len: got %0d expected %0d", req_log.size(), exp_win.size()); end
    for (int i = 0; i < exp_win.size() && i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_win[i]) begin bad++; $display("[TB] FAIL max_req_window: got %0d expected %0d", req_log[i], exp_win[i]); end
    end
    finish_out();
  endtask

  task automatic test_back_to_back();
    int         cyc;
    exp_t       e;
    logic [7:0] pix_list [2];
    set_stats(3, 8'd50, 8'd100, 8'd200);
    stat_delay = 0;
    pix_list[0] = 8'd120;
    pix_list[1] = 8'd30;
    for (int k = 0; k < 2; k++) begin
      if (pix_list[k] > 8'd50 && pix_list[k] < 8'd200) send_pixel(pix_list[k], pix_list[k], 1'b0);
      else send_pixel(pix_list[k], 8'd100, 1'b1);
      wait_out(cyc);
      e = sb_q.pop_front();
      total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL b2b_latency: got %0d expected 2", cyc); end
      total++; if (out_pixel !== e.pix) begin bad++; $display("[TB] FAIL b2b_pixel: got %0d expected %0d", out_pixel, e.pix); end
      total++; if (noiseF !== e.noise) begin bad++; $display("[TB] FAIL b2b_noiseF: got %0b expected %0b", noiseF, e.noise); end
      finish_out();
    end
  endtask

  task automatic test_reset_in_wait();
    int   cyc;
    int   r0;
    int   seen_valid;
    exp_t e;
    set_stats(3, 8'd0, 8'd0, 8'd0);
    set_stats(5, 8'd10, 8'd20, 8'd30);
    stat_delay = 4;
    r0 = req_cycles;
    send_pixel(8'd15, 8'd15, 1'b0);
    cyc = 0;
    while (req_cycles - r0 < 2 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++; if (req_cycles - r0 !== 2) begin bad++; $display("[TB] FAIL abort_reach_wait: got %0d requests expected 2", req_cycles - r0); end
    rst = 1'b1;
    #1;
    total++; if (win_size !== 4'd3) begin bad++; $display("[TB] FAIL abort_win_size: got %0d expected 3", win_size); end
    total++; if (out_pixel !== 8'd0) begin bad++; $display("[TB] FAIL abort_out_pixel: got %0d expected 0", out_pixel); end
    total++; if (noiseF !== 1'b0) begin bad++; $display("[TB] FAIL abort_noiseF: got %0b expected 0", noiseF); end
    total++; if (stat_req !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_outputs: got req=%0b valid=%0b expected 0 0", stat_req, out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    r0 = req_cycles;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen_valid++;
    end
    total++; if (seen_valid !== 0) begin bad++; $display("[TB] FAIL abort_no_output: got %0d valid cycles expected 0", seen_valid); end
    total++; if (req_cycles !== r0) begin bad++; $display("[TB] FAIL abort_no_request: got %0d new requests expected 0", req_cycles - r0); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_idle: got %0b expected 1", in_ready); end
    set_stats(3, 8'd50, 8'd100, 8'd200);
    stat_delay = 0;
    send_pixel(8'd100, 8'd100, 1'b0);
    wait_out(cyc);
    e = sb_q.pop_front();
    total++; if (cyc !== 2) begin bad++; $display("[TB] FAIL recover_latency: got %0d expected 2", cyc); end
    total++; if (out_pixel !== e.pix || noiseF !== e.noise) begin bad++; $display("[TB] FAIL recover_result: got %0d/%0b expected %0d/%0b", out_pixel, noiseF, e.pix, e.noise); end
    finish_out();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stage_b_fail();
    test_escalate_once();
    test_max_window();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
